animation_scheduler: RTL and testbench

//  Sequences LED animations for the Pong game. Sits between score/game logic and the LED

---
 rtl/animation_scheduler_if.sv | 53 +++++
 rtl/animation_scheduler.sv | 179 +++++++++++++++++
 tb/tb_animation_scheduler.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/animation_scheduler_if.sv
// Event/handshake bundle between game logic, scheduler and LED engine.
// The timeout signal exists only when ANIM_SCHED_TIMEOUT_EN is defined.
interface animation_scheduler_if #(
    parameter int DEPTH = 4
);
    logic                         goal_player_1;
    logic                         goal_player_2;
    logic                         win_player_1;
    logic                         win_player_2;
    logic                         anim_done;
    logic                         anim_start;
    logic [1:0]                   anim_type;
    logic                         busy;
    logic [$clog2(DEPTH+1)-1:0]   pending;
    logic                         overflow;
`ifdef ANIM_SCHED_TIMEOUT_EN
    logic                         timeout;
`endif

    modport master (
        output goal_player_1,
        output goal_player_2,
        output win_player_1,
        output win_player_2,
        output anim_done,
        input  anim_start,
        input  anim_type,
        input  busy,
        input  pending,
        input  overflow
`ifdef ANIM_SCHED_TIMEOUT_EN
        ,
        input  timeout
`endif
    );

    modport slave (
        input  goal_player_1,
        input  goal_player_2,
        input  win_player_1,
        input  win_player_2,
        input  anim_done,
        output anim_start,
        output anim_type,
        output busy,
        output pending,
        output overflow
`ifdef ANIM_SCHED_TIMEOUT_EN
        ,
        output timeout
`endif
    );
endinterface

// File: rtl/animation_scheduler.sv
// Pong LED animation scheduler: event FIFO, win priority, start/done with gap.
// Optional PLAY watchdog enabled by defining ANIM_SCHED_TIMEOUT_EN.
module animation_scheduler #(
    parameter int DEPTH          = 4,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic BALL_CLOCK,
    input logic RESET,
    animation_scheduler_if.slave bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        PLAY,
        GAP
    } state_t;

    state_t        state_q;
    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic [GW-1:0] gap_q;
    logic          lock_q;
    logic          start_q;
    logic          busy_q;
    logic          ovf_q;
    logic [1:0]    type_q;

    logic          ev_vld;
    logic          ev_win;
    logic [1:0]    ev_type;
    logic          pop;
    logic          push_goal;
    logic          push_win;
    logic          drop;
    logic          play_end;
    logic          lock_clr;
    logic          to_hit;

`ifdef ANIM_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q;
    logic          tout_q;
    assign to_hit = (state_q == PLAY) &&
                    (to_q == TW'(TIMEOUT_CYCLES - 1));
    assign bus.timeout = tout_q;
`else
    logic unused_to;
    assign to_hit    = 1'b0;
    assign unused_to = (TIMEOUT_CYCLES != 0);
`endif

    // One event per cycle; lower-priority simultaneous pulses are lost.
    always_comb begin
        ev_vld  = 1'b1;
        ev_win  = 1'b1;
        ev_type = 2'b10;
        if (bus.win_player_1) begin
            ev_type = 2'b10;
        end else if (bus.win_player_2) begin
            ev_type = 2'b11;
        end else if (bus.goal_player_1) begin
            ev_win  = 1'b0;
            ev_type = 2'b00;
        end else if (bus.goal_player_2) begin
            ev_win  = 1'b0;
            ev_type = 2'b01;
        end else begin
            ev_vld  = 1'b0;
            ev_win  = 1'b0;
            ev_type = 2'b00;
        end
    end

    assign pop       = (state_q == IDLE) && (cnt_q != '0);
    assign push_win  = ev_vld && ev_win && !lock_q;
    assign push_goal = ev_vld && !ev_win && !lock_q &&
                       ((cnt_q != CW'(DEPTH)) || pop);
    assign drop      = ev_vld && !ev_win && !lock_q && !push_goal;
    assign play_end  = (state_q == PLAY) && (bus.anim_done || to_hit);
    assign lock_clr  = play_end && type_q[1];

    // A win rewinds the read pointer onto itself, flushing queued goals.
    always_ff @(posedge BALL_CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_win || push_goal) begin
                mem_q[wr_q] <= ev_type;
                wr_q        <= wr_q + PW'(1);
            end
            if (push_win) begin
                rd_q  <= wr_q;
                cnt_q <= CW'(1);
            end else begin
                if (pop) rd_q <= rd_q + PW'(1);
                cnt_q <= cnt_q + CW'(push_goal) - CW'(pop);
            end
            if (push_win) lock_q <= 1'b1;
            else if (lock_clr) lock_q <= 1'b0;
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge BALL_CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            type_q  <= 2'b00;
            busy_q  <= 1'b0;
            gap_q   <= '0;
`ifdef ANIM_SCHED_TIMEOUT_EN
            to_q    <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= START;
                        start_q <= 1'b1;
                        type_q  <= mem_q[rd_q];
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state_q <= PLAY;
`ifdef ANIM_SCHED_TIMEOUT_EN
                    to_q    <= '0;
`endif
                end
                PLAY: begin
`ifdef ANIM_SCHED_TIMEOUT_EN
                    to_q <= to_q + TW'(1);
                    if (to_hit) tout_q <= 1'b1;
`endif
                    if (play_end) begin
                        gap_q <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (int'(gap_q) >= GAP_CYCLES - 1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.anim_start = start_q;
    assign bus.anim_type  = type_q;
    assign bus.busy       = busy_q;
    assign bus.pending    = cnt_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_animation_scheduler.sv
// Scoreboard bench for animation_scheduler: expected starts are queued by
// stimulus and popped by a monitor whenever anim_start is seen.
module tb_animation_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    animation_scheduler_if #(.DEPTH(4)) bus ();

    animation_scheduler #(
        .DEPTH(4),
        .GAP_CYCLES(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .BALL_CLOCK(clk),
        .RESET(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0] t;
        int         c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   starts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit g1, input bit g2,
                         input bit w1, input bit w2);
        bus.goal_player_1 = g1;
        bus.goal_player_2 = g2;
        bus.win_player_1  = w1;
        bus.win_player_2  = w2;
        tick();
        bus.goal_player_1 = 1'b0;
        bus.goal_player_2 = 1'b0;
        bus.win_player_1  = 1'b0;
        bus.win_player_2  = 1'b0;
    endtask

    task automatic done();
        bus.anim_done = 1'b1;
        tick();
        bus.anim_done = 1'b0;
    endtask

    task automatic expect_start(input logic [1:0] t, input int c);
        exp_t e;
        e.t = t;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (bus.anim_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(name, int'(bus.anim_start), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk(name, int'(bus.busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (bus.anim_start === 1'b1) begin
            starts++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL start_unexpected type %0d cyc %0d",
                         bus.anim_type, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.anim_type !== e.t ||
                    (e.c >= 0 && cyc != e.c)) begin
                    errors++;
                    $display("FAIL start_seq got type %0d cyc %0d want type %0d cyc %0d",
                             bus.anim_type, cyc, e.t, e.c);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim time expired");
        $fatal(1);
    end

    initial begin
        int t0;
        int s;
        bus.goal_player_1 = 1'b0;
        bus.goal_player_2 = 1'b0;
        bus.win_player_1  = 1'b0;
        bus.win_player_2  = 1'b0;
        bus.anim_done     = 1'b0;
        tick(3);
        rst = 1'b0;
        tick();

        chk("rst_start", int'(bus.anim_start), 0);
        chk("rst_type", int'(bus.anim_type), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_ovf", int'(bus.overflow), 0);

        // single goal: start at +2, done at +20, busy low at +29
        t0 = cyc;
        expect_start(2'b00, t0 + 2);
        pulse(1, 0, 0, 0);
        chk("t1_pending", int'(bus.pending), 1);
        tick();
        chk("t1_busy", int'(bus.busy), 1);
        chk("t1_pop", int'(bus.pending), 0);
        tick(18);
        done();
        tick(7);
        chk("t1_gap_busy", int'(bus.busy), 1);
        tick();
        chk("t1_busy_low", int'(bus.busy), 0);

        // overflow while engine held in PLAY
        t0 = cyc;
        expect_start(2'b00, t0 + 2);
        pulse(1, 0, 0, 0);
        tick(2);
        expect_start(2'b01, -1);
        expect_start(2'b00, -1);
        expect_start(2'b01, -1);
        expect_start(2'b01, -1);
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        chk("t2_pending", int'(bus.pending), 4);
        chk("t2_ovf", int'(bus.overflow), 1);
        done();
        repeat (4) begin
            wait_start("t2_start");
            tick(3);
            done();
        end
        wait_idle("t2_idle");
        chk("t2_empty", int'(bus.pending), 0);
        do_reset();
        chk("t2_ovf_rst", int'(bus.overflow), 0);

        // win flushes goals and locks out further events
        t0 = cyc;
        expect_start(2'b00, t0 + 2);
        pulse(1, 0, 0, 0);
        tick(2);
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        chk("t3_pending2", int'(bus.pending), 2);
        expect_start(2'b11, -1);
        pulse(0, 0, 0, 1);
        chk("t3_flush", int'(bus.pending), 1);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        chk("t3_locked", int'(bus.pending), 1);
        chk("t3_ovf", int'(bus.overflow), 0);
        done();
        wait_start("t3_win_start");
        chk("t3_win_type", int'(bus.anim_type), 3);
        tick(2);
        pulse(1, 0, 0, 0);
        chk("t3_ign_play", int'(bus.pending), 0);
        done();
        wait_idle("t3_idle");
        expect_start(2'b01, -1);
        pulse(0, 1, 0, 0);
        chk("t3_unlock", int'(bus.pending), 1);
        wait_start("t3_goal_start");
        tick(2);
        done();
        wait_idle("t3_idle2");
        chk("t3_ovf_end", int'(bus.overflow), 0);

        // simultaneous goal and win: win alone
        t0 = cyc;
        expect_start(2'b10, t0 + 2);
        pulse(1, 0, 1, 0);
        chk("t4_pending", int'(bus.pending), 1);
        wait_start("t4_start");
        chk("t4_type", int'(bus.anim_type), 2);
        tick(2);
        done();
        wait_idle("t4_idle");

        // reset mid-PLAY with two queued
        t0 = cyc;
        expect_start(2'b00, t0 + 2);
        pulse(1, 0, 0, 0);
        tick(2);
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        chk("t5_pending", int'(bus.pending), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_pending", int'(bus.pending), 0);
        chk("t5_rst_busy", int'(bus.busy), 0);
        chk("t5_rst_type", int'(bus.anim_type), 0);
        chk("t5_rst_start", int'(bus.anim_start), 0);
        tick(2);
        rst = 1'b0;
        s = starts;
        tick(20);
        chk("t5_no_replay", starts, s);
        chk("t5_busy_low", int'(bus.busy), 0);

`ifdef ANIM_SCHED_TIMEOUT_EN
        // watchdog: 16 PLAY cycles then GAP, queued goal follows
        t0 = cyc;
        expect_start(2'b00, t0 + 2);
        pulse(1, 0, 0, 0);
        tick();
        expect_start(2'b01, t0 + 28);
        pulse(0, 1, 0, 0);
        tick(15);
        chk("t6_to_pre", int'(bus.timeout), 0);
        tick();
        chk("t6_to_set", int'(bus.timeout), 1);
        chk("t6_gap_busy", int'(bus.busy), 1);
        wait_start("t6_next");
        tick(2);
        done();
        wait_idle("t6_idle");
        chk("t6_sticky", int'(bus.timeout), 1);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
